// File: rtl/sga_render_pkg.sv
// Shared constants, state encoding and coordinate helpers for the render sequencer.
package sga_render_pkg;

  localparam int unsigned GRID_W  = 6;
  localparam int unsigned GRID_H  = 6;
  localparam int unsigned COORD_W = 3;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned LEDS_W  = GRID_W * GRID_H;
  localparam int unsigned BIT_W   = $clog2(LEDS_W);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SCAN   = 3'd2,
    S_DRAIN  = 3'd3,
    S_APPLE  = 3'd4,
    S_COMMIT = 3'd5
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  // Row-major LED index; only meaningful for in-range coordinates.
  function automatic logic [BIT_W-1:0] xy_to_bit(input logic [COORD_W-1:0] x,
                                                 input logic [COORD_W-1:0] y);
    return BIT_W'(y) * BIT_W'(GRID_W) + BIT_W'(x);
  endfunction

endpackage

// File: rtl/render_sequencer_if.sv
// Request, body-RAM and LED-frame signals between game FSM, RAM and the render sequencer.
interface render_sequencer_if;
  import sga_render_pkg::*;

  logic               render_req;
  logic [IDX_W-1:0]   size;
  logic [COORD_W-1:0] appleX;
  logic [COORD_W-1:0] appleY;
  logic               mem_rd;
  logic [IDX_W-1:0]   mem_addr;
  logic [COORD_W-1:0] mem_x;
  logic [COORD_W-1:0] mem_y;
  logic               busy;
  logic               done;
  logic [LEDS_W-1:0]  leds;
  logic               self_hit;

  modport master (
    output render_req, size, appleX, appleY, mem_x, mem_y,
    input  mem_rd, mem_addr, busy, done, leds, self_hit
  );

  modport slave (
    input  render_req, size, appleX, appleY, mem_x, mem_y,
    output mem_rd, mem_addr, busy, done, leds, self_hit
  );

endinterface

// File: rtl/xy_decoder.sv
// Combinational coordinate decoder: one-hot LED mask plus in-range flag.
module xy_decoder
  import sga_render_pkg::*;
(
  input  coord_t            xy_i,
  output logic [LEDS_W-1:0] mask_c,
  output logic              in_range_c
);

  always_comb begin
    in_range_c = (32'(xy_i.x) < GRID_W) && (32'(xy_i.y) < GRID_H);
    mask_c     = '0;
    if (in_range_c) mask_c = LEDS_W'(1) << xy_to_bit(xy_i.x, xy_i.y);
  end

endmodule

// File: rtl/render_sequencer.sv
// Render sequencer: scans body RAM into a scratch frame, adds the apple, commits to leds.
// Optional macro BLINK_APPLE_EN draws the apple only on alternate frames.
module render_sequencer
  import sga_render_pkg::*;
(
  input  logic              clock,
  input  logic              restart,
  render_sequencer_if.slave bus
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  size_q, size_d;
  logic              pending_q, pending_d;
  logic [LEDS_W-1:0] scratch_q, scratch_d;
  logic [LEDS_W-1:0] leds_q, leds_d;
  logic              hit_q, hit_d;
  logic              self_hit_q, self_hit_d;
  coord_t            head_q, head_d;
  logic              head_ok_q, head_ok_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              mem_rd_q, mem_rd_d;
  logic              rd_v_q, rd_first_q;

  coord_t            seg_c, apple_c;
  logic [LEDS_W-1:0] seg_mask_c, apple_mask_c;
  logic              seg_in_c, apple_in_c, apple_en_c;

  assign seg_c   = '{x: bus.mem_x,  y: bus.mem_y};
  assign apple_c = '{x: bus.appleX, y: bus.appleY};

  xy_decoder u_seg_dec (
    .xy_i       (seg_c),
    .mask_c     (seg_mask_c),
    .in_range_c (seg_in_c)
  );

  xy_decoder u_apple_dec (
    .xy_i       (apple_c),
    .mask_c     (apple_mask_c),
    .in_range_c (apple_in_c)
  );

`ifdef BLINK_APPLE_EN
  logic phase_q;
  always_ff @(posedge clock or posedge restart) begin
    if (restart)                    phase_q <= 1'b1;
    else if (state_q == S_COMMIT)   phase_q <= ~phase_q;
  end
  assign apple_en_c = phase_q;
`else
  assign apple_en_c = 1'b1;
`endif

  // State and datapath registers.
  always_ff @(posedge clock or posedge restart) begin
    if (restart) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      size_q     <= '0;
      pending_q  <= 1'b0;
      scratch_q  <= '0;
      leds_q     <= '0;
      hit_q      <= 1'b0;
      self_hit_q <= 1'b0;
      head_q     <= '0;
      head_ok_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      rd_v_q     <= 1'b0;
      rd_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      size_q     <= size_d;
      pending_q  <= pending_d;
      scratch_q  <= scratch_d;
      leds_q     <= leds_d;
      hit_q      <= hit_d;
      self_hit_q <= self_hit_d;
      head_q     <= head_d;
      head_ok_q  <= head_ok_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      mem_rd_q   <= mem_rd_d;
      rd_v_q     <= mem_rd_q;
      rd_first_q <= mem_rd_q && (idx_q == '0);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.render_req || pending_q) state_d = S_CLEAR;
      S_CLEAR:  state_d = (bus.size == '0) ? S_APPLE : S_SCAN;
      S_SCAN:   if (idx_q == size_q - IDX_W'(1)) state_d = S_DRAIN;
      S_DRAIN:  state_d = S_APPLE;
      S_APPLE:  state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    idx_d      = idx_q;
    size_d     = size_q;
    pending_d  = pending_q;
    scratch_d  = scratch_q;
    leds_d     = leds_q;
    hit_d      = hit_q;
    self_hit_d = self_hit_q;
    head_d     = head_q;
    head_ok_d  = head_ok_q;
    done_d     = 1'b0;
    busy_d     = (state_d != S_IDLE);
    mem_rd_d   = (state_d == S_SCAN);

    // Idle either launches the pending frame or has nothing pending; busy requests collapse.
    if (state_q == S_IDLE)  pending_d = 1'b0;
    else if (bus.render_req) pending_d = 1'b1;

    // Returning segment: the first one is the head, later ones are compared against it.
    if (rd_v_q) begin
      if (seg_in_c) scratch_d = scratch_q | seg_mask_c;
      if (rd_first_q) begin
        head_d    = seg_c;
        head_ok_d = seg_in_c;
      end else if (seg_in_c && head_ok_q && (seg_c == head_q)) begin
        hit_d = 1'b1;
      end
    end

    case (state_q)
      S_CLEAR: begin
        scratch_d = '0;
        hit_d     = 1'b0;
        head_ok_d = 1'b0;
        idx_d     = '0;
        size_d    = bus.size;
      end
      S_SCAN: begin
        if (state_d == S_SCAN) idx_d = idx_q + IDX_W'(1);
      end
      S_APPLE: begin
        if (apple_in_c && apple_en_c) scratch_d = scratch_q | apple_mask_c;
      end
      S_COMMIT: begin
        leds_d     = scratch_q;
        self_hit_d = hit_q;
        done_d     = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = idx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.leds     = leds_q;
  assign bus.self_hit = self_hit_q;

endmodule
